// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: SOF/ADDR/LEN/payload/XOR-checksum frame controller.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl #(
   parameter int unsigned MAX_LEN      = 16,
   parameter logic [7:0]  SOF_BYTE     = 8'hA5,
   parameter int unsigned TIMEOUT_CLKS = 2160
) (
   input  logic       uart_clock,
   input  logic       uart_reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] frm_addr,
   output logic [7:0] frm_len,
   output logic       frm_done,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       frm_err,
   output logic [1:0] err_code,
   output logic       busy
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [1:0] E_CSUM = 2'd0;
   localparam logic [1:0] E_LEN  = 2'd1;
   localparam logic [1:0] E_TMO  = 2'd2;
   localparam logic [1:0] E_OVR  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LEN,
      S_PAYLOAD,
      S_CSUM,
      S_DRAIN
   } state_t;

   state_t     state;
   logic [7:0] hdr_addr;
   logic [7:0] len;
   logic [7:0] len_m1;
   logic [7:0] csum;
   logic [7:0] wr_ptr;
   logic [7:0] rd_ptr;
   logic [7:0] buf_mem [MAX_LEN];
   logic       tmo_hit;

   assign len_m1    = len - 8'd1;
   assign busy      = (state != S_IDLE);
   assign out_valid = (state == S_DRAIN);
   assign out_last  = out_valid && (rd_ptr == len_m1);
   assign out_data  = out_valid ? buf_mem[rd_ptr[AW-1:0]] : 8'h00;

`ifdef UART_FRAME_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);

   logic [TW-1:0] timer;
   logic          timed;

   assign timed   = (state == S_ADDR) || (state == S_LEN) ||
                    (state == S_PAYLOAD) || (state == S_CSUM);
   assign tmo_hit = timed && !rx_valid &&
                    (timer == TW'(TIMEOUT_CLKS - 1));

   // Inter-byte timer: restarts on every byte, runs only mid-frame
   always_ff @(posedge uart_clock) begin
      if (uart_reset || !timed || rx_valid || tmo_hit)
         timer <= '0;
      else
         timer <= timer + 1'b1;
   end
`else
   assign tmo_hit = 1'b0;

   // Timeout disabled: the parameter stays for a uniform interface only.
   if (TIMEOUT_CLKS == 0) begin : g_tmo_unused
   end
`endif

   // Payload capture; contents are only read back after a verified checksum
   always_ff @(posedge uart_clock) begin
      if (!uart_reset && state == S_PAYLOAD && rx_valid)
         buf_mem[wr_ptr[AW-1:0]] <= rx_data;
   end

   // Frame sequencing, checksum accumulation and status pulses
   always_ff @(posedge uart_clock) begin
      if (uart_reset) begin
         state    <= S_IDLE;
         hdr_addr <= 8'h00;
         len      <= 8'h00;
         csum     <= 8'h00;
         wr_ptr   <= 8'h00;
         rd_ptr   <= 8'h00;
         frm_addr <= 8'h00;
         frm_len  <= 8'h00;
         frm_done <= 1'b0;
         frm_err  <= 1'b0;
         err_code <= 2'd0;
      end else begin
         frm_done <= 1'b0;
         frm_err  <= 1'b0;
         if (tmo_hit) begin
            frm_err  <= 1'b1;
            err_code <= E_TMO;
            state    <= S_IDLE;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (rx_valid && rx_data == SOF_BYTE)
                     state <= S_ADDR;
               end
               S_ADDR: begin
                  if (rx_valid) begin
                     hdr_addr <= rx_data;
                     csum     <= rx_data;
                     state    <= S_LEN;
                  end
               end
               S_LEN: begin
                  if (rx_valid) begin
                     len    <= rx_data;
                     csum   <= csum ^ rx_data;
                     wr_ptr <= 8'h00;
                     if (rx_data > 8'(MAX_LEN)) begin
                        frm_err  <= 1'b1;
                        err_code <= E_LEN;
                        state    <= S_IDLE;
                     end else if (rx_data == 8'h00) begin
                        state <= S_CSUM;
                     end else begin
                        state <= S_PAYLOAD;
                     end
                  end
               end
               S_PAYLOAD: begin
                  if (rx_valid) begin
                     csum   <= csum ^ rx_data;
                     wr_ptr <= wr_ptr + 8'd1;
                     if (wr_ptr == len_m1)
                        state <= S_CSUM;
                  end
               end
               S_CSUM: begin
                  if (rx_valid) begin
                     if (rx_data == csum) begin
                        frm_done <= 1'b1;
                        frm_addr <= hdr_addr;
                        frm_len  <= len;
                        rd_ptr   <= 8'h00;
                        state    <= (len != 8'h00) ? S_DRAIN : S_IDLE;
                     end else begin
                        frm_err  <= 1'b1;
                        err_code <= E_CSUM;
                        state    <= S_IDLE;
                     end
                  end
               end
               S_DRAIN: begin
                  if (rx_valid) begin
                     frm_err  <= 1'b1;
                     err_code <= E_OVR;
                  end
                  if (out_ready) begin
                     rd_ptr <= rd_ptr + 8'd1;
                     if (rd_ptr == len_m1)
                        state <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
